mcu_irq_hub: RTL and testbench
==============================

# mcu_irq_hub

Multi-channel, parametrised interrupt and event-data hub for the 832 MCU subsystem. Each channel is an event from the APF bridge clock domain, such as dataslot update, reload request or save request, that carries a DATA_W-bit payload. The block moves the event and its payload into clk_sys with a toggle handshake and presents pending, mask, overrun and vector registers on the MCU's 0xFFFF_xxxx peripheral bus. It drives a single level interrupt into the CPU.

## Interface
- CHANNELS, 4: number of event channels, legal range 1..16.
- DATA_W, 32: payload width per channel, legal range 1..32.
- SYNC_STAGES, 3: synchroniser depth for each handshake direction, legal range 2..4.
- AUTO_CLEAR, 1: when 1, a CPU read of CHAN_DATA[n] clears pending[n].
- clk_sys  in  1  MCU/system clock.
- reset_n  in  1  asynchronous, active-low; resets both clock domains.
- src_clk  in  1  event source clock (clk_74a).
- src_trigger  in  CHANNELS  per-channel event strobe, sampled on src_clk.
- src_data  in  CHANNELS*DATA_W  per-channel payload; channel n occupies [n*DATA_W +: DATA_W].
- cpu_sel  in  1  bus request for this block (clk_sys).
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  5  word index.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  single-cycle acknowledge.
- irq  out  1  level interrupt to the CPU, registered.

## Operation
- Register map (word index):
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write.
  - 2 OVERRUN: read; write-1-to-clear.
  - 3 VECTOR: read only; bit31 = any unmasked pending, bits[3:0] = lowest-index unmasked pending channel.
  - 16+n CHAN_DATA[n]: read only, zero-extended to 32 bits.
  - Unused indices read 0 and ignore writes.
- Source side, per channel:
  - A src_trigger with the channel idle captures src_data into the hold register, toggles req and marks the channel busy.
  - The channel stays busy until the synchronised ack toggle equals req.
  - A trigger while busy sets a coalesce flag and overwrites the hold register with the newest data only after ack returns; the freshest payload wins.
  - On ack return with coalesce set, the channel resends immediately.
- System side, per channel:
  - When the synchronised req differs from the local copy, latch the hold register into CHAN_DATA[n], set pending[n] and toggle ack back.
  - If pending[n] was already 1, also set overrun[n].
- irq is the registered value of |(PENDING & MASK).
- Simultaneous event arrival and W1C on the same channel: arrival wins, pending stays 1.
- Simultaneous AUTO_CLEAR read and arrival: the read returns the old data, and pending stays 1 with the new data latched.

## Timing
- Reset values: PENDING, OVERRUN, MASK, CHAN_DATA, cpu_rdata, cpu_ack and irq are all 0. All toggles and busy/coalesce flags are 0.
- A read returns data with cpu_ack one cycle after cpu_sel. Writes take effect on that same edge.
- cpu_ack is never asserted on two consecutive cycles. A held cpu_sel is serviced every other cycle.
- Latency from src trigger to pending set: 1 src_clk cycle plus SYNC_STAGES+1 clk_sys cycles. irq follows pending by 1 clk_sys cycle.
- The src hold register is stable from the req toggle until ack returns, so multi-bit sampling on clk_sys is safe without per-bit synchronisers.
- Round-trip busy time: about SYNC_STAGES+2 clk_sys cycles plus SYNC_STAGES+1 src_clk cycles.
- reset_n asserted mid-handshake abandons the event. After release, no spurious pending may appear because all toggles restart equal.

## Structure
- Shared package `mcu_irq_hub_pkg`: register index constants (REG_PENDING, REG_MASK, REG_OVERRUN, REG_VECTOR, REG_CHAN_BASE = 16) and parameter range checks.
- Sub-module `mcu_irq_hub_chan`: one channel's source capture, coalesce logic, req/ack toggle synchronisers and system-side latch. Instantiated CHANNELS times with a generate loop.
- The top level holds the bus decoder, the MASK register, the priority encoder and the irq register.

## Test plan
- Single event: CHANNELS=4, MASK=0xF, trigger ch2 with data 0x1234_5678. Required: irq rises within 6 clk_sys cycles, VECTOR = 0x8000_0002, CHAN_DATA[2] = 0x1234_5678. Reading CHAN_DATA[2] clears PENDING bit 2 and irq falls.
- Masking and priority: trigger ch1 and ch3 together with MASK=0x8. Required: VECTOR = 0x8000_0003. Then write MASK=0xA; required: VECTOR = 0x8000_0001.
- Coalesce: trigger ch0 with 0xA, then 0xB and 0xC while busy. Required: exactly two arrivals, with final CHAN_DATA[0] = 0xC and OVERRUN[0] = 1 if pending was not cleared between them.
- W1C race: write PENDING=0x1 on the same clk_sys edge that a ch0 arrival is latched. Required: PENDING[0] = 1.
- Reset mid-handshake: pulse reset_n low after the ch1 req toggle, before ack returns. Required: all registers 0, no pending after release, and the next ch1 trigger delivers normally.
- Clock ratio sweep: src_clk from 3x faster to 3x slower than clk_sys with random triggers. Required: every delivered payload equals a value that was actually presented, and no lost irq for unmasked channels.

Source files
------------

// File: rtl/mcu_irq_hub_pkg.sv
// Shared constants for the MCU interrupt/event hub: bus geometry, register word
// indices and the legal parameter envelope.
package mcu_irq_hub_pkg;

  localparam int unsigned BUS_W   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned MAX_CH  = 16;
  localparam int unsigned VEC_PAD = BUS_W - 1 - VEC_W;

  localparam logic [ADDR_W-1:0] REG_PENDING   = 5'd0;
  localparam logic [ADDR_W-1:0] REG_MASK      = 5'd1;
  localparam logic [ADDR_W-1:0] REG_OVERRUN   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_VECTOR    = 5'd3;
  localparam logic [ADDR_W-1:0] REG_CHAN_BASE = 5'd16;

  function automatic bit params_ok(input int unsigned channels,
                                   input int unsigned data_w,
                                   input int unsigned sync_stages);
    return (channels >= 1) && (channels <= MAX_CH) &&
           (data_w >= 1) && (data_w <= BUS_W) &&
           (sync_stages >= 2) && (sync_stages <= 4);
  endfunction

endpackage

// File: rtl/mcu_irq_hub_chan.sv
// One event channel: source-side capture with coalescing, req/ack toggle
// handshake across clock domains, and the system-side payload latch.
module mcu_irq_hub_chan
  import mcu_irq_hub_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic              i_reset_n,
  input  logic              i_src_clk,
  input  logic              i_clk_sys,
  input  logic              i_trigger,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_arrive_c,
  output logic [DATA_W-1:0] o_data
);

  logic                   r_req;
  logic                   r_coal;
  logic [DATA_W-1:0]      r_hold;
  logic [DATA_W-1:0]      r_next;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic                   r_ack;
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [DATA_W-1:0]      r_data;

  logic                   w_busy;

  // Busy while the returned ack toggle has not caught up with req.
  assign w_busy = r_req ^ r_ack_sync[SYNC_STAGES-1];

  // Source side: r_hold only changes together with a req toggle, so it is
  // stable for the whole time the system side may sample it.
  always_ff @(posedge i_src_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_req      <= 1'b0;
      r_coal     <= 1'b0;
      r_hold     <= '0;
      r_next     <= '0;
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
      if (w_busy) begin
        if (i_trigger) begin
          r_coal <= 1'b1;
          r_next <= i_data;
        end
      end else if (r_coal || i_trigger) begin
        r_req  <= ~r_req;
        r_coal <= 1'b0;
        r_hold <= i_trigger ? i_data : r_next;
      end
    end
  end

  assign o_arrive_c = r_req_sync[SYNC_STAGES-1] ^ r_ack;

  // System side: latch the payload and return the ack toggle.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_req_sync <= '0;
      r_ack      <= 1'b0;
      r_data     <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
      if (o_arrive_c) begin
        r_ack  <= ~r_ack;
        r_data <= r_hold;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mcu_irq_hub.sv
// MCU interrupt/event hub top: per-channel CDC instances, peripheral bus
// decoder, PENDING/MASK/OVERRUN registers, vector priority encoder and irq.
module mcu_irq_hub
  import mcu_irq_hub_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 3,
  parameter bit          AUTO_CLEAR  = 1'b1
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       src_clk,
  input  logic [CHANNELS-1:0]        src_trigger,
  input  logic [CHANNELS*DATA_W-1:0] src_data,
  input  logic                       cpu_sel,
  input  logic                       cpu_wr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [BUS_W-1:0]           cpu_wdata,
  output logic [BUS_W-1:0]           cpu_rdata,
  output logic                       cpu_ack,
  output logic                       irq
);

  if (!params_ok(CHANNELS, DATA_W, SYNC_STAGES)) begin : g_bad_params
    $error("mcu_irq_hub: parameter out of range");
  end

  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_overrun;
  logic [CHANNELS-1:0] r_mask;
  logic [BUS_W-1:0]    r_rdata;
  logic                r_ack;
  logic                r_irq;

  logic [CHANNELS-1:0] w_arrive;
  logic [DATA_W-1:0]   w_chan_data [CHANNELS];
  logic [BUS_W-1:0]    w_data16    [MAX_CH];
  logic [CHANNELS-1:0] w_active;
  logic [CHANNELS-1:0] w_pend_clr;
  logic [CHANNELS-1:0] w_ovr_clr;
  logic [VEC_W-1:0]    w_idx;
  logic [VEC_W-1:0]    w_vec_idx;
  logic [BUS_W-1:0]    w_rd_mux;
  logic                w_take;
  logic                w_chan_ok;
  logic                w_mask_we;
  logic                w_any;
  logic                w_unused_ok;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mcu_irq_hub_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .i_reset_n  (reset_n),
      .i_src_clk  (src_clk),
      .i_clk_sys  (clk_sys),
      .i_trigger  (src_trigger[g]),
      .i_data     (src_data[g*DATA_W +: DATA_W]),
      .o_arrive_c (w_arrive[g]),
      .o_data     (w_chan_data[g])
    );
  end

  // Pad channel data to a full 16-entry window so unused slots read zero.
  for (genvar g = 0; g < MAX_CH; g++) begin : g_pad
    if (g < CHANNELS) begin : g_used
      assign w_data16[g] = BUS_W'(w_chan_data[g]);
    end else begin : g_empty
      assign w_data16[g] = '0;
    end
  end

  // A held cpu_sel is accepted only when no ack is outstanding.
  assign w_take    = cpu_sel & ~r_ack;
  assign w_idx     = cpu_addr[VEC_W-1:0];
  assign w_chan_ok = (cpu_addr >= REG_CHAN_BASE) && (32'(w_idx) < CHANNELS);
  assign w_active  = r_pending & r_mask;
  assign w_any     = |w_active;

  always_comb begin
    w_vec_idx = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (w_active[i]) w_vec_idx = VEC_W'(i);
    end
  end

  // Write strobes, including the read side effect on CHAN_DATA.
  always_comb begin
    w_pend_clr = '0;
    w_ovr_clr  = '0;
    w_mask_we  = 1'b0;
    if (w_take && cpu_wr) begin
      case (cpu_addr)
        REG_PENDING: w_pend_clr = cpu_wdata[CHANNELS-1:0];
        REG_MASK:    w_mask_we  = 1'b1;
        REG_OVERRUN: w_ovr_clr  = cpu_wdata[CHANNELS-1:0];
        default:     ;
      endcase
    end
    if (AUTO_CLEAR && w_take && !cpu_wr && w_chan_ok) begin
      w_pend_clr = CHANNELS'(MAX_CH'(1) << w_idx);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_chan_ok) begin
      w_rd_mux = w_data16[w_idx];
    end else begin
      case (cpu_addr)
        REG_PENDING: w_rd_mux = BUS_W'(r_pending);
        REG_MASK:    w_rd_mux = BUS_W'(r_mask);
        REG_OVERRUN: w_rd_mux = BUS_W'(r_overrun);
        REG_VECTOR:  w_rd_mux = {w_any, {VEC_PAD{1'b0}}, w_vec_idx};
        default:     w_rd_mux = '0;
      endcase
    end
  end

  // Arrival is OR-ed in after clears, so it wins a same-edge W1C.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_mask    <= '0;
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ack     <= w_take;
      r_rdata   <= (w_take && !cpu_wr) ? w_rd_mux : '0;
      if (w_mask_we) r_mask <= cpu_wdata[CHANNELS-1:0];
      r_pending <= (r_pending & ~w_pend_clr) | w_arrive;
      r_overrun <= (r_overrun & ~w_ovr_clr) | (w_arrive & r_pending);
      r_irq     <= w_any;
    end
  end

  assign w_unused_ok = ^cpu_wdata;

  assign cpu_rdata = r_rdata;
  assign cpu_ack   = r_ack;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mcu_irq_hub.sv
// Scoreboard bench for mcu_irq_hub: bus tasks push expected read data, a
// negedge monitor pops and compares on every cpu_ack.
`timescale 1ps/1ps
module tb_mcu_irq_hub;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;

  logic              clk_sys = 1'b0;
  logic              src_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [CH-1:0]     src_trigger;
  logic [CH*DW-1:0]  src_data;
  logic              cpu_sel;
  logic              cpu_wr;
  logic [4:0]        cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              irq;

  int unsigned src_half = 5000;

  always #5000 clk_sys = ~clk_sys;
  always #(src_half) src_clk = ~src_clk;

  mcu_irq_hub #(
    .CHANNELS    (CH),
    .DATA_W      (DW),
    .SYNC_STAGES (3),
    .AUTO_CLEAR  (1'b1)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .src_clk     (src_clk),
    .src_trigger (src_trigger),
    .src_data    (src_data),
    .cpu_sel     (cpu_sel),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .irq         (irq)
  );

  typedef struct {
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   prev_ack = 1'b0;

  // Monitor: every ack pops one expectation; reads are compared.
  always @(negedge clk_sys) begin
    exp_t e;
    if (cpu_ack) begin
      n_tests++;
      if (prev_ack) begin
        n_fail++;
        $display("FAIL ack_gap: cpu_ack high on two consecutive cycles, required a gap");
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with rdata=0x%08h and no transaction outstanding", cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          n_tests++;
          if (cpu_rdata !== e.data) begin
            n_fail++;
            $display("FAIL %s: rdata=0x%08h required 0x%08h", e.name, cpu_rdata, e.data);
          end
        end
      end
    end
    prev_ack = cpu_ack;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, ex);
    end
  endtask

  task automatic bus(input bit wr_en, input logic [4:0] addr, input logic [31:0] wd,
                     input bit chk, input logic [31:0] ex, input string nm);
    exp_t e;
    @(negedge clk_sys);
    e.chk = chk; e.data = ex; e.name = nm;
    exp_q.push_back(e);
    cpu_sel = 1'b1; cpu_wr = wr_en; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk_sys);
    cpu_sel = 1'b0; cpu_wr = 1'b0;
    n_tests++;
    if (!cpu_ack) begin
      n_fail++;
      $display("FAIL %s_ack: cpu_ack=0 one cycle after cpu_sel, required 1", nm);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ex, input string nm);
    bus(1'b0, a, 32'h0, 1'b1, ex, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'h0, "write");
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Trigger one source clock; returns just after the capturing edge.
  task automatic trig_mask(input logic [CH-1:0] m);
    @(negedge src_clk);
    src_trigger = m;
    @(posedge src_clk);
    #1;
    src_trigger = '0;
  endtask

  task automatic trig1(input int ch, input logic [31:0] d);
    @(negedge src_clk);
    src_data[ch*DW +: DW] = d;
    src_trigger = CH'(1) << ch;
    @(posedge src_clk);
    #1;
    src_trigger = '0;
  endtask

  task automatic wait_irq(input logic lvl, input int max_cyc, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk_sys);
      #1;
      if (irq === lvl) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: irq=%b, required %b within %0d cycles", nm, irq, lvl, max_cyc);
    end
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d [CH];
    logic [CH-1:0] m;
    int unsigned halves [5] = '{1667, 2500, 5000, 10000, 15000};
    int low;

    src_trigger = '0; src_data = '0;
    cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cycles(3);
    check("rst_ack", 32'(cpu_ack), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    cycles(2);

    // Reset values and register boundaries.
    rd(5'd0, 32'h0, "rst_pending");
    rd(5'd1, 32'h0, "rst_mask");
    rd(5'd2, 32'h0, "rst_overrun");
    rd(5'd3, 32'h0, "rst_vector");
    rd(5'd18, 32'h0, "rst_chan2");
    wr(5'd1, 32'hFFFF_FFFF);
    rd(5'd1, 32'h0000_000F, "mask_width");

    // Held cpu_sel: serviced every other cycle.
    @(negedge clk_sys);
    exp_q.push_back('{1'b1, 32'h0000_000F, "held_rd0"});
    exp_q.push_back('{1'b1, 32'h0000_000F, "held_rd1"});
    cpu_sel = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd1;
    cycles(4);
    cpu_sel = 1'b0;
    cycles(2);

    // Single event on ch2.
    trig1(2, 32'h1234_5678);
    wait_irq(1'b1, 6, "single_irq_rise");
    rd(5'd3, 32'h8000_0002, "single_vector");
    rd(5'd0, 32'h0000_0004, "single_pending");
    rd(5'd18, 32'h1234_5678, "single_data");
    rd(5'd0, 32'h0, "single_autoclear");
    wait_irq(1'b0, 3, "single_irq_fall");
    rd(5'd20, 32'h0, "chan_out_of_range");
    wr(5'd7, 32'hFFFF_FFFF);
    rd(5'd7, 32'h0, "unused_index");

    // Masking and priority.
    wr(5'd1, 32'h8);
    src_data[1*DW +: DW] = 32'h11;
    src_data[3*DW +: DW] = 32'h33;
    trig_mask(4'b1010);
    cycles(10);
    rd(5'd3, 32'h8000_0003, "prio_mask8");
    wr(5'd1, 32'hA);
    rd(5'd3, 32'h8000_0001, "prio_maskA");
    rd(5'd0, 32'h0000_000A, "prio_pending");
    rd(5'd2, 32'h0, "prio_no_overrun");
    wr(5'd0, 32'hF);
    rd(5'd0, 32'h0, "pending_w1c");
    wait_irq(1'b0, 3, "prio_irq_fall");

    // Coalesce: A then B, C while busy.
    trig1(0, 32'hA);
    trig1(0, 32'hB);
    trig1(0, 32'hC);
    cycles(30);
    rd(5'd2, 32'h1, "coal_overrun");
    rd(5'd0, 32'h1, "coal_pending");
    rd(5'd16, 32'hC, "coal_data");
    cycles(30);
    rd(5'd0, 32'h0, "coal_no_third");
    wr(5'd2, 32'h1);
    rd(5'd2, 32'h0, "overrun_w1c");

    // W1C on the arrival edge: capture P0, arrival latched at P4.
    trig1(0, 32'h77);
    repeat (3) @(negedge clk_sys);
    wr(5'd0, 32'h1);
    rd(5'd0, 32'h1, "w1c_race_pending");
    rd(5'd2, 32'h0, "w1c_race_overrun");
    rd(5'd16, 32'h77, "w1c_race_data");
    rd(5'd0, 32'h0, "w1c_race_clear");

    // Reset while ch1 req is still in the synchroniser.
    wr(5'd1, 32'h2);
    trig1(1, 32'h55);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1000;
    reset_n = 1'b0;
    cycles(2);
    check("midrst_ack", 32'(cpu_ack), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    cycles(20);
    rd(5'd0, 32'h0, "midrst_pending");
    rd(5'd1, 32'h0, "midrst_mask");
    rd(5'd2, 32'h0, "midrst_overrun");
    rd(5'd17, 32'h0, "midrst_chan1");
    wr(5'd1, 32'h2);
    trig1(1, 32'h66);
    wait_irq(1'b1, 6, "midrst_irq_rise");
    rd(5'd3, 32'h8000_0001, "midrst_vector");
    rd(5'd17, 32'h66, "midrst_data");
    cycles(20);

    // Clock ratio sweep with random payloads.
    wr(5'd1, 32'hF);
    foreach (halves[k]) begin
      src_half = halves[k];
      cycles(10);
      for (int r = 0; r < 4; r++) begin
        m = CH'($urandom_range(1, 15));
        low = 0;
        for (int c = CH - 1; c >= 0; c--) begin
          d[c] = $urandom;
          src_data[c*DW +: DW] = d[c];
          if (m[c]) low = c;
        end
        trig_mask(m);
        wait_irq(1'b1, 10, "sweep_irq");
        rd(5'd3, 32'h8000_0000 | 32'(low), "sweep_vector");
        for (int c = 0; c < CH; c++) begin
          if (m[c]) rd(5'(16 + c), d[c], "sweep_data");
        end
        rd(5'd0, 32'h0, "sweep_pending");
        cycles(25);
      end
    end

    cycles(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
